m10k_sram_dp: RTL
=================

# m10k_sram_dp

Parametrised simple-dual-port on-chip SRAM for NPU weight/activation buffers, targeting M10K block RAM. One write port with byte enables, one read port, configurable width/depth, selectable read-during-write behaviour, and a post-reset clear sequencer that zeroes the array before traffic is accepted. Sits between the NPU load/store DMA (write side) and the MAC array operand fetch (read side).

## Interface
- DATA_W, 16, word width in bits; must be a multiple of BYTE_W
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words
- BYTE_W, 8, bits per byte-enable lane; NB = DATA_W/BYTE_W
- RDW_NEW, 0, same-address read/write in one cycle: 0 = return old data, 1 = return merged new data
- INIT_CLEAR, 1, 1 = zero all words after reset; 0 = contents undefined, no clear phase
- clk  in  1  sole clock, all logic on posedge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  NB  byte enables; lane i covers bits [i*BYTE_W +: BYTE_W]
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data, held until next accepted read
- rd_valid  out  1  one-cycle pulse, rd_data carries result of an accepted read
- busy  out  1  clear in progress; wr_en/rd_en ignored while high

## Operation
- States: CLEAR, READY. Reset enters CLEAR if INIT_CLEAR=1, else READY.
- CLEAR: internal counter clr_addr from 0; each cycle writes all-zero word to clr_addr, increments; after writing DEPTH-1 moves to READY. Wrap-around of clr_addr never occurs.
- In CLEAR: wr_en, rd_en ignored (dropped, not queued); rd_valid stays 0.
- reset asserted mid-CLEAR: clr_addr returns to 0, clear restarts from word 0.
- READY: write updates only bytes with wr_be[i]=1; wr_be=0 with wr_en=1 is a no-op. Read accepted whenever rd_en=1.
- Simultaneous read and write, different addresses: independent.
- Same address, RDW_NEW=0: rd_data = contents before the write. RDW_NEW=1: per lane, wr_be[i] ? wr_data lane : old lane (implemented by registering write data/enables and a hit flag, merged at output).
- Memory contents are not affected by reset except through CLEAR.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, busy = INIT_CLEAR.
- Clear duration: busy high for exactly DEPTH cycles after the cycle reset is sampled low; first accepted access is on the cycle busy is observed low.
- Read latency L = 1 cycle (rd_en at edge N -> rd_valid/rd_data at edge N+1); L = 2 with SRAM_OUTREG_EN.
- Write visible to a different-cycle read issued at edge N+1 or later.
- Back-to-back reads: one per cycle, rd_valid continuously high.

## Configuration
- SRAM_OUTREG_EN defined: extra output register after the array (and after the RDW merge); L = 2, rd_valid delayed identically; reset clears both stages. Undefined: L = 1, rd_data driven from array read register.

## Structure
- Package sram_pkg: state enum (ST_CLEAR, ST_READY), RDW_OLD/RDW_NEW constants, latency function returning 1 or 2 from the macro.
- Sub-module m10k_array: bare byte-enabled storage (one write port, registered read, M10K ramstyle, no reset); top holds FSM, clear counter, bypass merge, valid pipeline.

## Test plan
- Reset with DEPTH=16, INIT_CLEAR=1 -> busy high 16 cycles; read every address -> all 0x0000, rd_valid one cycle after each rd_en.
- Write 0xABCD to addr 5, wr_be=2'b01, after prior 0x1234 -> read addr 5 returns 0x12CD.
- Same-cycle write 0xBEEF / read addr 7 holding 0x0001, wr_be=2'b11 -> RDW_NEW=0 returns 0x0001, RDW_NEW=1 returns 0xBEEF; next read returns 0xBEEF.
- Assert reset at clear cycle 9, release -> busy high full 16 cycles again; rd_en/wr_en during busy produce no rd_valid and no write.
- Streaming reads 0..15 with SRAM_OUTREG_EN -> rd_valid contiguous, data lags rd_en by 2 cycles; without macro by 1.
- INIT_CLEAR=0 -> busy 0 from reset, write then read accepted on first cycle after reset.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the m10k_sram_dp buffer slice.
// rd_latency() reflects the SRAM_OUTREG_EN build option.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    function automatic int unsigned rd_latency();
`ifdef SRAM_OUTREG_EN
        return 2;
`else
        return 1;
`endif
    endfunction

endpackage

// File: rtl/m10k_array.sv
// Bare byte-enabled storage: one write port, one registered read port, no reset.
// Same-address read and write in one cycle returns the pre-write word.
module m10k_array
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned BYTE_W = 8
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [DATA_W/BYTE_W-1:0]   wbe_i,
    input  logic                       re_i,
    input  logic [ADDR_W-1:0]          raddr_i,
    output logic [DATA_W-1:0]          rdata_o
);

    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    (* ramstyle = "M10K" *) logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/m10k_sram_dp.sv
// Simple-dual-port M10K buffer with post-reset clear sequencer and selectable RDW.
// Define SRAM_OUTREG_EN to add an output register stage (read latency 2).
module m10k_sram_dp #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned RDW_NEW    = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [DATA_W/BYTE_W-1:0]  wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      busy
);
    // Explicit imports: the RDW_NEW parameter shares its name with a package constant.
    import sram_pkg::state_t;
    import sram_pkg::ST_CLEAR;
    import sram_pkg::ST_READY;

    localparam int unsigned NB = DATA_W / BYTE_W;

    state_t             state_q;
    logic [ADDR_W-1:0]  clr_addr_q;
    logic               ready, wr_acc, rd_acc;

    assign ready  = (state_q == ST_READY);
    assign wr_acc = wr_en & ready;
    assign rd_acc = rd_en & ready;
    assign busy   = ~ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            if (clr_addr_q == '1) begin
                state_q <= ST_READY;
            end else begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end
        end
    end

    logic               arr_we;
    logic [ADDR_W-1:0]  arr_addr;
    logic [DATA_W-1:0]  arr_wdata, arr_rdata;
    logic [NB-1:0]      arr_be;

    always_comb begin
        arr_we    = wr_acc;
        arr_addr  = wr_addr;
        arr_wdata = wr_data;
        arr_be    = wr_be;
        if (!ready) begin
            arr_we    = 1'b1;
            arr_addr  = clr_addr_q;
            arr_wdata = '0;
            arr_be    = '1;
        end
    end

    m10k_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYTE_W (BYTE_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .waddr_i (arr_addr),
        .wdata_i (arr_wdata),
        .wbe_i   (arr_be),
        .re_i    (rd_acc),
        .raddr_i (rd_addr),
        .rdata_o (arr_rdata)
    );

    // Bypass state only advances on accepted reads so rd_data holds between reads.
    logic               rd_valid_q, rd_seen_q, hit_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [NB-1:0]      wbe_q;
    logic [DATA_W-1:0]  merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_seen_q <= 1'b1;
                hit_q     <= wr_acc && (wr_addr == rd_addr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            wdata_q <= wr_data;
            wbe_q   <= wr_be;
        end
    end

    always_comb begin
        merged = arr_rdata;
        if ((RDW_NEW == sram_pkg::RDW_NEW) && hit_q) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe_q[i]) begin
                    merged[i*BYTE_W +: BYTE_W] = wdata_q[i*BYTE_W +: BYTE_W];
                end
            end
        end
        // The array read register has no reset; mask it until a read lands.
        if (!rd_seen_q) begin
            merged = '0;
        end
    end

`ifdef SRAM_OUTREG_EN
    logic [DATA_W-1:0]  out_data_q;
    logic               out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_data_q <= merged;
            end
        end
    end

    assign rd_data  = out_data_q;
    assign rd_valid = out_valid_q;
`else
    assign rd_data  = merged;
    assign rd_valid = rd_valid_q;
`endif

endmodule
